// File: rtl/alu_op_arbiter.sv
// Round-robin arbiter sharing one ALU among four requesters; launches operands,
// waits ALU_LAT cycles, returns the captured result with a one-cycle done pulse.
//   state  | meaning
//   IDLE   | sample req, pick round-robin winner, launch operands
//   EXEC   | operands held, counting down ALU latency
//   RESP   | done pulse high for one cycle, result valid
module alu_op_arbiter #(
  parameter int DATA_W  = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            req,
  input  logic [7:0]            req_op,
  input  logic [4*DATA_W-1:0]   req_a,
  input  logic [4*DATA_W-1:0]   req_b,
  output logic [3:0]            gnt,
  output logic [3:0]            done,
  output logic [DATA_W:0]       rsp_data,
  output logic                  busy,
  output logic                  alu_s0,
  output logic                  alu_s1,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  input  logic [DATA_W:0]       alu_y
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t     state_q, state_d;
  logic [1:0] ptr_q;
  logic [1:0] win;
  logic [1:0] win_q;
  logic [3:0] cnt_q;
  logic       launch;
  logic       finish;
  logic [3:0] gnt_d;
  logic [3:0] done_d;

  // First requester at or after the rotating pointer wins.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    win   = ptr_q;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (|req) state_d = S_EXEC;
      S_EXEC:  if (cnt_q == 4'd1) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    launch = (state_q == S_IDLE) && (|req);
    finish = (state_q == S_EXEC) && (cnt_q == 4'd1);
    gnt_d  = launch ? (4'b0001 << win) : 4'b0000;
    done_d = finish ? (4'b0001 << win_q) : 4'b0000;
  end

  assign busy = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt      <= '0;
      done     <= '0;
      rsp_data <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_s0   <= 1'b0;
      alu_s1   <= 1'b0;
      ptr_q    <= '0;
      win_q    <= '0;
      cnt_q    <= '0;
    end else begin
      gnt  <= gnt_d;
      done <= done_d;
      if (launch) begin
        alu_a  <= req_a[DATA_W*win +: DATA_W];
        alu_b  <= req_b[DATA_W*win +: DATA_W];
        alu_s0 <= req_op[2*win];
        alu_s1 <= req_op[2*win+1];
        ptr_q  <= win + 2'd1;
        win_q  <= win;
        cnt_q  <= 4'(ALU_LAT);
      end else if (state_q == S_EXEC) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (finish) rsp_data <= alu_y;
    end
  end

endmodule

// File: doc/alu_op_arbiter.md
Name: alu_op_arbiter

Overview:
Round-robin arbiter and sequencer that shares one 4-bit ALU among four requesters. It drives the ALU operands and the 2-bit operation select {alu_s1, alu_s0}, which feeds the 2-to-4 decoder (S0/S1 → R0..R3). It waits a fixed ALU latency, then returns the result to the granted requester with a one-cycle done pulse. Only one operation is in flight at a time.

Parameters:
DATA_W, 4, operand width; result width is DATA_W+1 (carry/borrow in MSB)
ALU_LAT, 1, cycles from operand launch to valid alu_y; legal range 1..15

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  4  per-requester request level; bit i = requester i
req_op  input  8  op select, requester i at [2i+1:2i]; encoding {S1,S0}
req_a  input  4*DATA_W  operand A, requester i at [DATA_W*i +: DATA_W]
req_b  input  4*DATA_W  operand B, same packing as req_a
gnt  output  4  one-hot grant pulse, registered
done  output  4  one-hot completion pulse, registered
rsp_data  output  DATA_W+1  captured ALU result, valid while done≠0, held afterwards
busy  output  1  high in EXEC and RESP
alu_s0  output  1  op select bit 0 to decoder S0
alu_s1  output  1  op select bit 1 to decoder S1
alu_a  output  DATA_W  operand A to ALU
alu_b  output  DATA_W  operand B to ALU
alu_y  input  DATA_W+1  ALU result

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous and active-low.
- Reset (async, immediate): state=IDLE, ptr=0, cnt=0. gnt, done, rsp_data, busy, alu_s0, alu_s1, alu_a and alu_b are all 0.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE: req is sampled at each edge. If req≠0, pick winner w, the first set bit scanning ptr, ptr+1, ... mod 4. At that edge:
  - alu_a ← a[w], alu_b ← b[w], {alu_s1, alu_s0} ← op[w]
  - gnt ← onehot(w), ptr ← (w+1) mod 4, cnt ← ALU_LAT, state → EXEC
  - If req=0, stay in IDLE with all pulses 0.
- EXEC:
  - gnt is high only in the first EXEC cycle, then cleared.
  - alu_a, alu_b and the select bits are held stable for the whole of EXEC and RESP.
  - cnt decrements each edge. At the edge where cnt==1: rsp_data ← alu_y, done ← onehot(w), state → RESP.
- RESP: lasts exactly one cycle with done high. At the next edge, done ← 0 and state → IDLE.
- ALU outputs after RESP: alu_a, alu_b and the select bits keep their last values in IDLE until the next grant.
- Timing:
  - Grant edge G. gnt is high in cycle G..G+1.
  - done is high in cycle G+ALU_LAT..G+ALU_LAT+1.
  - Back-to-back throughput is one operation per ALU_LAT+2 cycles (IDLE sample, ALU_LAT EXEC cycles, 1 RESP).
- req, req_op, req_a and req_b are ignored outside IDLE.
- Requester contract:
  - Hold req and operands stable until gnt is seen.
  - Deassert req before the return to IDLE if no further operation is wanted; a still-high req is treated as a new request.
- Fairness: a requester holding req continuously waits at most 3 other operations.
- Simultaneous requests: the rotating pointer resolves them. There is no fixed priority except after reset, where ptr=0 favours requester 0.
- Reset mid-operation (EXEC/RESP): the operation is aborted, no done is issued, and ptr returns to 0.
- Width rule: alu_y is captured verbatim (DATA_W+1 bits). The block performs no arithmetic on it.
- gnt and done never have more than one bit set. gnt and done are never high in the same cycle when ALU_LAT≥1.

Test Plan:
1. Assert rst_n=0 mid-run → all outputs 0 immediately, without waiting for a clock edge; busy=0.
2. Single request, ALU_LAT=1, bench ALU y=a+b: req=0001, op0=2'b10, a0=4'h3, b0=4'h5 → gnt=0001 for 1 cycle, {alu_s1,alu_s0}=10, alu_a=3, alu_b=5; done=0001 one cycle later with rsp_data=5'h08; busy high for 2 cycles.
3. req=1111 held continuously → gnt order 0001, 0010, 0100, 1000, 0001, with grants spaced ALU_LAT+2 cycles apart; each done matches the preceding gnt index.
4. Rotation check: grant requester 1 (ptr becomes 2), then req=1011 held → grants to 3, then 0, then 1.
5. Reset mid-EXEC: ALU_LAT=3, pull rst_n low one cycle after gnt → no done pulse. After release, req=0110 → gnt=0010 (ptr reset to 0).
6. ALU_LAT=3, change req_a/req_op and toggle req[2] during EXEC → alu_a and the select bits stay unchanged; done fires exactly 3 cycles after gnt; rsp_data equals alu_y sampled at that edge, e.g. 5'h1F for y=5'h1F.
